fix_serializer: RTL and testbench
=================================

# fix_serializer

FIX tag=value message serializer: the transmit-side counterpart of `fix_parser`. It accepts binary tag numbers and streamed value bytes from the order/session logic and emits an ASCII FIX byte stream, one byte per cycle, in the form `tag '=' value SOH`. It drives the same `tag_s_o`/`tag_e_o`/`value_s_o`/`value_e_o` markers that `fix_parser` produces, so a loopback into the parser yields identical markers. Optionally, it appends the `10=NNN<SOH>` checksum trailer.

## Interface
Parameters:
- TAG_W, 14, width of binary tag input; legal tags are 1..9999 (at most 4 ASCII digits)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- tag_valid_i  in  1  tag offered
- tag_i  in  TAG_W  binary tag number
- tag_ready_o  out  1  tag accepted when tag_valid_i && tag_ready_o
- val_valid_i  in  1  value byte offered
- val_i  in  8  value byte (raw ASCII; must not be 0x01)
- val_last_i  in  1  marks last byte of the current value
- val_ready_o  out  1  value byte accepted when val_valid_i && val_ready_o
- eom_valid_i  in  1  end-of-message request
- eom_ready_o  out  1  eom accepted when eom_valid_i && eom_ready_o
- data_o  out  8  serialized byte
- data_valid_o  out  1  data_o valid
- data_ready_i  in  1  downstream accepts data_o
- tag_s_o, tag_e_o, value_s_o, value_e_o  out  1 each  field markers qualified by data_valid_o
- tag_err_o  out  1  one-cycle pulse on an illegal tag

## Operation
- FSM states: IDLE, TAG, EQ, VAL, SOH, DROP, CK_TAG, CK_DIG, CK_SOH.
- IDLE: tag_ready_o=1 and eom_ready_o=1. Tag has priority if both are valid in the same cycle.
- On tag accept, digits are computed via BCD with leading zeros suppressed. Then IDLE→TAG; if tag is 0 or >9999: tag_err_o pulses, IDLE→DROP.
- TAG: emit digits MSB first; tag_s_o on first digit, tag_e_o on last (both set for a 1-digit tag). TAG→EQ.
- EQ: emit 0x3D. EQ→VAL.
- VAL: val_ready_o = output slot free. Each accepted byte is emitted; value_s_o on first, value_e_o on byte with val_last_i (both for a 1-byte value). After the last byte, VAL→SOH. Every value has at least one byte.
- SOH: emit 0x01. SOH→IDLE.
- DROP: consume value bytes with val_ready_o=1, emit nothing, and return to IDLE after val_last_i.
- Checksum: 8-bit running sum mod 256 of every byte emitted since reset or the last trailer, including '=' and SOH.
- With the macro enabled, eom accept leads IDLE→CK_TAG, which emits "10=" (0x31, 0x30, 0x3D). The tag markers apply to 0x31/0x30. Then CK_DIG emits the frozen sum as 3 zero-padded decimal digits, with value markers on the first and last. CK_SOH emits 0x01, clears the sum, and returns to IDLE.
- The sum is frozen at eom accept; trailer bytes are not added.
- Reset: all outputs 0, FSM IDLE, sum 0. Reset mid-field abandons the field; no partial SOH is emitted.

## Timing
- All outputs are registered.
- The first tag digit appears on data_o the cycle after tag accept.
- data_o and all markers are held stable while data_valid_o && !data_ready_i. No byte is dropped or duplicated.
- Throughput is one byte per cycle under continuous data_ready_i and val_valid_i.
- A field costs digits+1+len+1 cycles.
- val_ready_o is combinational from state and output-slot occupancy: 1 only in VAL/DROP when the slot is empty or draining this cycle.
- tag_ready_o and eom_ready_o are asserted only in IDLE with the output slot free or draining.

## Configuration
- FIX_CHECKSUM_EN defined: checksum accumulator and CK_* states are present; eom emits the trailer.
- Undefined: no accumulator or CK_* logic. An eom accept in IDLE is a no-op completing in one cycle, and no bytes are emitted.

## Structure
- Package `fix_pkg` holds:
  - constants FIX_SOH=8'h01, FIX_EQ=8'h3D, FIX_CKSUM_TAG=10, FIX_MAX_TAG=9999
  - the state enum typedef
  - a 4-digit BCD struct typedef
- Sub-module `fix_bin2bcd`: combinational double-dabble, TAG_W in, four BCD digits plus a digit count out. It is reused for the 3-digit checksum.

## Test plan
- Tag 35, value "8" (val_last on the only byte), ready=1 → 33 35 3D 38 01; tag_s_o on 33, tag_e_o on 35, value_s_o/value_e_o both on 38.
- Tag 1, value "A", then eom (macro on) → 31 3D 41 01 31 30 3D 31 37 36 01 (sum 176).
- Tag 9999, value "XY", with data_ready_i toggling every other cycle → 39 39 39 39 3D 58 59 01; data_o held stable during stalls, no duplicates.
- Tag 0, value "ZZ" → tag_err_o pulses one cycle, both value bytes consumed, no output bytes, next tag 9 emits normally.
- Assert rst during the VAL byte of tag 52 → next cycle all outputs 0, FSM IDLE; the following eom emits "10=000" + SOH.
- Tag_valid and eom_valid both high in IDLE → tag served first, eom accepted only after SOH.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared constants, FSM state encoding and BCD digit bundle for the FIX
// tag=value serializer.
package fix_pkg;

    localparam logic [7:0]  FIX_SOH       = 8'h01;
    localparam logic [7:0]  FIX_EQ        = 8'h3D;
    localparam int unsigned FIX_CKSUM_TAG = 32'd10;
    localparam int unsigned FIX_MAX_TAG   = 32'd9999;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        TAG    = 4'd1,
        EQ     = 4'd2,
        VAL    = 4'd3,
        SOH    = 4'd4,
        DROP   = 4'd5,
        CK_TAG = 4'd6,
        CK_DIG = 4'd7,
        CK_SOH = 4'd8
    } fix_state_e;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } bcd4_t;

    // ASCII character of the BCD digit selected by idx (0 = units).
    function automatic logic [7:0] bcd_ascii(input bcd4_t b, input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd3:    d = b.d3;
            2'd2:    d = b.d2;
            2'd1:    d = b.d1;
            default: d = b.d0;
        endcase
        return {4'h3, d};
    endfunction

endpackage

// File: rtl/fix_bin2bcd.sv
// Combinational double-dabble: binary to four BCD digits plus the number of
// significant digits (leading zeros suppressed, at least one digit).
module fix_bin2bcd
    import fix_pkg::*;
#(
    parameter int W = 14
) (
    input  logic [W-1:0] bin_i,
    output bcd4_t        bcd_o,
    output logic [2:0]   ndig_o
);

    logic [15:0] sh_s;

    // Shift-and-add-3; digits beyond 9999 fall off the top and are never used.
    always_comb begin
        sh_s = 16'h0000;
        for (int i = W - 1; i >= 0; i--) begin
            for (int n = 0; n < 4; n++) begin
                sh_s[n*4 +: 4] = (sh_s[n*4 +: 4] >= 4'd5) ? sh_s[n*4 +: 4] + 4'd3 : sh_s[n*4 +: 4];
            end
            sh_s = {sh_s[14:0], bin_i[i]};
        end
        bcd_o = sh_s;
        if (sh_s[15:12] != 4'd0) begin
            ndig_o = 3'd4;
        end else if (sh_s[11:8] != 4'd0) begin
            ndig_o = 3'd3;
        end else if (sh_s[7:4] != 4'd0) begin
            ndig_o = 3'd2;
        end else begin
            ndig_o = 3'd1;
        end
    end

endmodule

// File: rtl/fix_serializer.sv
// FIX tag=value serializer: emits "tag=value<SOH>" one byte per cycle with
// fix_parser-compatible markers. Define FIX_CHECKSUM_EN for the 10=NNN trailer.
module fix_serializer
    import fix_pkg::*;
#(
    parameter int TAG_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tag_valid_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             tag_ready_o,
    input  logic             val_valid_i,
    input  logic [7:0]       val_i,
    input  logic             val_last_i,
    output logic             val_ready_o,
    input  logic             eom_valid_i,
    output logic             eom_ready_o,
    output logic [7:0]       data_o,
    output logic             data_valid_o,
    input  logic             data_ready_i,
    output logic             tag_s_o,
    output logic             tag_e_o,
    output logic             value_s_o,
    output logic             value_e_o,
    output logic             tag_err_o
);

    fix_state_e  state_q, state_d;
    bcd4_t       bcd_q, bcd_d;
    logic [1:0]  idx_q, idx_d;
    logic        first_q, first_d;
    logic        err_q, err_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic [3:0]  mark_q, mark_d;

    bcd4_t       tag_bcd_s;
    logic [2:0]  tag_ndig_s;
    logic        tag_legal_s;
    logic        slot_free_s;
    logic        idle_s;
    logic        emit_s;
    logic [7:0]  emit_byte_s;
    logic [3:0]  emit_mark_s;
    logic        count_s;

    fix_bin2bcd #(.W(TAG_W)) u_tag_bcd (
        .bin_i  (tag_i),
        .bcd_o  (tag_bcd_s),
        .ndig_o (tag_ndig_s)
    );

`ifdef FIX_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    bcd4_t       ck_bcd_s;
    logic [2:0]  unused_ck_ndig_s;

    fix_bin2bcd #(.W(8)) u_ck_bcd (
        .bin_i  (sum_q),
        .bcd_o  (ck_bcd_s),
        .ndig_o (unused_ck_ndig_s)
    );
`else
    logic        unused_count_s;
    logic [7:0]  unused_byte_s;
    assign unused_count_s = count_s;
    assign unused_byte_s  = emit_byte_s;
`endif

    assign slot_free_s = !data_valid_q || data_ready_i;
    assign tag_legal_s = (tag_i != {TAG_W{1'b0}}) && (32'(tag_i) <= FIX_MAX_TAG);
    assign idle_s      = !rst && (state_q == IDLE) && slot_free_s;
    assign tag_ready_o = idle_s;
    assign eom_ready_o = idle_s && !tag_valid_i;
    assign val_ready_o = !rst && slot_free_s && ((state_q == VAL) || (state_q == DROP));

    // Next-state, byte selection and output-slot load/hold.
    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        idx_d       = idx_q;
        first_d     = first_q;
        err_d       = 1'b0;
        emit_s      = 1'b0;
        emit_byte_s = 8'h00;
        emit_mark_s = 4'b0000;
        count_s     = 1'b0;
`ifdef FIX_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (tag_valid_i && idle_s) begin
                    if (tag_legal_s) begin
                        // First digit leaves on the accept edge to save a cycle.
                        emit_s      = 1'b1;
                        emit_byte_s = bcd_ascii(tag_bcd_s, 2'(tag_ndig_s - 3'd1));
                        emit_mark_s = {1'b1, (tag_ndig_s == 3'd1), 2'b00};
                        count_s     = 1'b1;
                        bcd_d       = tag_bcd_s;
                        idx_d       = 2'(tag_ndig_s - 3'd2);
                        state_d     = (tag_ndig_s == 3'd1) ? EQ : TAG;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DROP;
                    end
                end else if (eom_valid_i && eom_ready_o) begin
`ifdef FIX_CHECKSUM_EN
                    emit_s      = 1'b1;
                    emit_byte_s = {4'h3, 4'(FIX_CKSUM_TAG / 32'd10)};
                    emit_mark_s = 4'b1000;
                    bcd_d       = ck_bcd_s;
                    idx_d       = 2'd1;
                    state_d     = CK_TAG;
`else
                    state_d     = IDLE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            TAG: begin
                if (slot_free_s) begin
                    emit_s      = 1'b1;
                    emit_byte_s = bcd_ascii(bcd_q, idx_q);
                    emit_mark_s = {1'b0, (idx_q == 2'd0), 2'b00};
                    count_s     = 1'b1;
                    idx_d       = idx_q - 2'd1;
                    state_d     = (idx_q == 2'd0) ? EQ : TAG;
                end else begin
                    state_d = TAG;
                end
            end
            EQ: begin
                if (slot_free_s) begin
                    emit_s      = 1'b1;
                    emit_byte_s = FIX_EQ;
                    count_s     = 1'b1;
                    first_d     = 1'b1;
                    state_d     = VAL;
                end else begin
                    state_d = EQ;
                end
            end
            VAL: begin
                if (val_valid_i && val_ready_o) begin
                    emit_s      = 1'b1;
                    emit_byte_s = val_i;
                    emit_mark_s = {2'b00, first_q, val_last_i};
                    count_s     = 1'b1;
                    first_d     = 1'b0;
                    state_d     = val_last_i ? SOH : VAL;
                end else begin
                    state_d = VAL;
                end
            end
            SOH: begin
                if (slot_free_s) begin
                    emit_s      = 1'b1;
                    emit_byte_s = FIX_SOH;
                    count_s     = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = SOH;
                end
            end
            DROP: begin
                if (val_valid_i && val_ready_o && val_last_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
`ifdef FIX_CHECKSUM_EN
            CK_TAG: begin
                if (slot_free_s && (idx_q == 2'd1)) begin
                    emit_s      = 1'b1;
                    emit_byte_s = {4'h3, 4'(FIX_CKSUM_TAG % 32'd10)};
                    emit_mark_s = 4'b0100;
                    idx_d       = 2'd0;
                end else if (slot_free_s) begin
                    emit_s      = 1'b1;
                    emit_byte_s = FIX_EQ;
                    idx_d       = 2'd2;
                    state_d     = CK_DIG;
                end else begin
                    state_d = CK_TAG;
                end
            end
            CK_DIG: begin
                if (slot_free_s) begin
                    emit_s      = 1'b1;
                    emit_byte_s = bcd_ascii(bcd_q, idx_q);
                    emit_mark_s = {2'b00, (idx_q == 2'd2), (idx_q == 2'd0)};
                    idx_d       = idx_q - 2'd1;
                    state_d     = (idx_q == 2'd0) ? CK_SOH : CK_DIG;
                end else begin
                    state_d = CK_DIG;
                end
            end
            CK_SOH: begin
                if (slot_free_s) begin
                    emit_s      = 1'b1;
                    emit_byte_s = FIX_SOH;
                    sum_d       = 8'h00;
                    state_d     = IDLE;
                end else begin
                    state_d = CK_SOH;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef FIX_CHECKSUM_EN
        if (count_s) begin
            sum_d = sum_q + emit_byte_s;
        end else begin
            sum_d = sum_d;
        end
`endif

        if (slot_free_s) begin
            data_valid_d = emit_s;
            data_d       = emit_s ? emit_byte_s : 8'h00;
            mark_d       = emit_s ? emit_mark_s : 4'b0000;
        end else begin
            data_valid_d = data_valid_q;
            data_d       = data_q;
            mark_d       = mark_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bcd_q        <= 16'h0000;
            idx_q        <= 2'd0;
            first_q      <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            mark_q       <= 4'b0000;
`ifdef FIX_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            bcd_q        <= bcd_d;
            idx_q        <= idx_d;
            first_q      <= first_d;
            err_q        <= err_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            mark_q       <= mark_d;
`ifdef FIX_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign tag_s_o      = mark_q[3];
    assign tag_e_o      = mark_q[2];
    assign value_s_o    = mark_q[1];
    assign value_e_o    = mark_q[0];
    assign tag_err_o    = err_q;

endmodule

// File: tb/tb_fix_serializer.sv
// Directed bench for fix_serializer; trailer expectations follow FIX_CHECKSUM_EN.
module tb_fix_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tag_valid_i = 1'b0;
    logic [13:0] tag_i = 14'd0;
    logic        tag_ready_o;
    logic        val_valid_i = 1'b0;
    logic [7:0]  val_i = 8'h00;
    logic        val_last_i = 1'b0;
    logic        val_ready_o;
    logic        eom_valid_i = 1'b0;
    logic        eom_ready_o;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        data_ready_i = 1'b1;
    logic        tag_s_o, tag_e_o, value_s_o, value_e_o, tag_err_o;

    int          n_checks = 0;
    int          n_fails = 0;
    int          err_cycles = 0;
    logic        toggle_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [11:0] prev_word = 12'h000;
    logic [11:0] out_q[$];

    fix_serializer #(.TAG_W(14)) dut (
        .clk(clk), .rst(rst),
        .tag_valid_i(tag_valid_i), .tag_i(tag_i), .tag_ready_o(tag_ready_o),
        .val_valid_i(val_valid_i), .val_i(val_i), .val_last_i(val_last_i), .val_ready_o(val_ready_o),
        .eom_valid_i(eom_valid_i), .eom_ready_o(eom_ready_o),
        .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .tag_s_o(tag_s_o), .tag_e_o(tag_e_o), .value_s_o(value_s_o), .value_e_o(value_e_o),
        .tag_err_o(tag_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (toggle_en) data_ready_i = ~data_ready_i;
    end

    // Byte collector and stall-stability watcher, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                n_checks++;
                if (!data_valid_o || {tag_s_o, tag_e_o, value_s_o, value_e_o, data_o} !== prev_word) begin
                    n_fails++;
                    $display("FAIL stall_hold: got %h valid %b expected %h", {tag_s_o, tag_e_o, value_s_o, value_e_o, data_o}, data_valid_o, prev_word);
                end
            end
            if (data_valid_o && data_ready_i) out_q.push_back({tag_s_o, tag_e_o, value_s_o, value_e_o, data_o});
            if (tag_err_o) err_cycles++;
            stall_prev = data_valid_o && !data_ready_i;
            prev_word  = {tag_s_o, tag_e_o, value_s_o, value_e_o, data_o};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_tag(input logic [13:0] t);
        int k;
        tag_valid_i = 1'b1;
        tag_i = t;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tag_ready_o) break;
        end
        if (k == 60) begin
            n_checks++; n_fails++;
            $display("FAIL tag_timeout: got no tag_ready expected tag_ready for tag %0d", t);
        end
        @(posedge clk); #1;
        tag_valid_i = 1'b0;
    endtask

    task automatic send_val(input logic [7:0] b, input logic last);
        int k;
        val_valid_i = 1'b1;
        val_i = b;
        val_last_i = last;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (val_ready_o) break;
        end
        if (k == 60) begin
            n_checks++; n_fails++;
            $display("FAIL val_timeout: got no val_ready expected val_ready for byte %h", b);
        end
        @(posedge clk); #1;
        val_valid_i = 1'b0;
        val_last_i = 1'b0;
    endtask

    task automatic send_eom();
        int k;
        eom_valid_i = 1'b1;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (eom_ready_o) break;
        end
        if (k == 60) begin
            n_checks++; n_fails++;
            $display("FAIL eom_timeout: got no eom_ready expected eom_ready");
        end
        @(posedge clk); #1;
        eom_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({data_valid_o, data_o, tag_s_o, tag_e_o, value_s_o, value_e_o, tag_err_o, tag_ready_o, val_ready_o, eom_ready_o} !== 17'd0) begin
            n_fails++;
            $display("FAIL reset_outputs: got valid %b data %h rdy %b%b%b expected all zero", data_valid_o, data_o, tag_ready_o, val_ready_o, eom_ready_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tag_ready_o, eom_ready_o, val_ready_o, data_valid_o} !== 4'b1100) begin
            n_fails++;
            $display("FAIL reset_idle: got tag/eom/val/dv %b expected 1100", {tag_ready_o, eom_ready_o, val_ready_o, data_valid_o});
        end
        @(posedge clk); #1;
        out_q.delete();
    endtask

    task automatic test_tag1_eom();
`ifdef FIX_CHECKSUM_EN
        logic [11:0] exp [11] = '{12'hC31, 12'h03D, 12'h341, 12'h001, 12'h831, 12'h430, 12'h03D, 12'h231, 12'h037, 12'h136, 12'h001};
`else
        logic [11:0] exp [4] = '{12'hC31, 12'h03D, 12'h341, 12'h001};
`endif
        send_tag(14'd1);
        send_val(8'h41, 1'b1);
        send_eom();
        repeat (15) @(posedge clk); #1;
        n_checks++;
        if (out_q.size() != $size(exp)) begin
            n_fails++;
            $display("FAIL tag1_count: got %0d bytes expected %0d", out_q.size(), $size(exp));
        end
        for (int i = 0; i < $size(exp) && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL tag1_byte%0d: got %h expected %h", i, out_q[i], exp[i]);
            end
        end
        n_checks++;
        if (tag_ready_o !== 1'b1) begin
            n_fails++;
            $display("FAIL tag1_idle: got tag_ready %b expected 1", tag_ready_o);
        end
        out_q.delete();
    endtask

    task automatic test_basic();
        logic [11:0] exp [5] = '{12'h833, 12'h435, 12'h03D, 12'h338, 12'h001};
        send_tag(14'd35);
        send_val(8'h38, 1'b1);
        repeat (6) @(posedge clk); #1;
        n_checks++;
        if (out_q.size() != 5) begin
            n_fails++;
            $display("FAIL basic_count: got %0d bytes expected 5", out_q.size());
        end
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, out_q[i], exp[i]);
            end
        end
        out_q.delete();
    endtask

    task automatic test_stall();
        logic [11:0] exp [8] = '{12'h839, 12'h039, 12'h039, 12'h439, 12'h03D, 12'h258, 12'h159, 12'h001};
        toggle_en = 1'b1;
        send_tag(14'd9999);
        send_val(8'h58, 1'b0);
        send_val(8'h59, 1'b1);
        repeat (20) @(posedge clk); #1;
        toggle_en = 1'b0;
        data_ready_i = 1'b1;
        repeat (4) @(posedge clk); #1;
        n_checks++;
        if (out_q.size() != 8) begin
            n_fails++;
            $display("FAIL stall_count: got %0d bytes expected 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL stall_byte%0d: got %h expected %h", i, out_q[i], exp[i]);
            end
        end
        out_q.delete();
    endtask

    task automatic test_drop();
        logic [11:0] exp [4] = '{12'hC39, 12'h03D, 12'h36B, 12'h001};
        err_cycles = 0;
        send_tag(14'd0);
        send_val(8'h5A, 1'b0);
        send_val(8'h5A, 1'b1);
        repeat (4) @(posedge clk); #1;
        n_checks++;
        if (err_cycles != 1 || out_q.size() != 0) begin
            n_fails++;
            $display("FAIL drop_zero: got err_cycles %0d bytes %0d expected 1 and 0", err_cycles, out_q.size());
        end
        send_tag(14'd10000);
        send_val(8'h61, 1'b1);
        repeat (4) @(posedge clk); #1;
        n_checks++;
        if (err_cycles != 2 || out_q.size() != 0) begin
            n_fails++;
            $display("FAIL drop_10000: got err_cycles %0d bytes %0d expected 2 and 0", err_cycles, out_q.size());
        end
        send_tag(14'd9);
        send_val(8'h6B, 1'b1);
        repeat (5) @(posedge clk); #1;
        n_checks++;
        if (out_q.size() != 4 || err_cycles != 2) begin
            n_fails++;
            $display("FAIL drop_next_count: got %0d bytes err %0d expected 4 and 2", out_q.size(), err_cycles);
        end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL drop_next_byte%0d: got %h expected %h", i, out_q[i], exp[i]);
            end
        end
        out_q.delete();
    endtask

    task automatic test_reset_mid_val();
        int k;
        logic [11:0] pre [3] = '{12'h835, 12'h432, 12'h03D};
`ifdef FIX_CHECKSUM_EN
        logic [11:0] exp [7] = '{12'h831, 12'h430, 12'h03D, 12'h230, 12'h030, 12'h130, 12'h001};
`else
        logic [11:0] exp [1] = '{12'h000};
`endif
        send_tag(14'd52);
        val_valid_i = 1'b1;
        val_i = 8'h41;
        val_last_i = 1'b1;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (val_ready_o) break;
        end
        if (k == 30) begin
            n_checks++; n_fails++;
            $display("FAIL rstval_timeout: got no val_ready expected val_ready");
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        val_valid_i = 1'b0;
        val_last_i = 1'b0;
        n_checks++;
        if ({data_valid_o, data_o, tag_s_o, tag_e_o, value_s_o, value_e_o, tag_err_o} !== 13'd0) begin
            n_fails++;
            $display("FAIL rstval_outputs: got valid %b data %h expected 0 and 00", data_valid_o, data_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tag_ready_o, eom_ready_o, data_valid_o} !== 3'b110) begin
            n_fails++;
            $display("FAIL rstval_idle: got tag/eom/dv %b expected 110", {tag_ready_o, eom_ready_o, data_valid_o});
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_q.size() != 3) begin
            n_fails++;
            $display("FAIL rstval_pre_count: got %0d bytes expected 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== pre[i]) begin
                n_fails++;
                $display("FAIL rstval_pre%0d: got %h expected %h", i, out_q[i], pre[i]);
            end
        end
        out_q.delete();
        send_eom();
        repeat (10) @(posedge clk); #1;
`ifdef FIX_CHECKSUM_EN
        n_checks++;
        if (out_q.size() != 7) begin
            n_fails++;
            $display("FAIL rstval_trailer_count: got %0d bytes expected 7", out_q.size());
        end
        for (int i = 0; i < 7 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL rstval_trailer%0d: got %h expected %h", i, out_q[i], exp[i]);
            end
        end
`else
        n_checks++;
        if (out_q.size() != 0 || exp[0] !== 12'h000 || tag_ready_o !== 1'b1) begin
            n_fails++;
            $display("FAIL rstval_eom_noop: got %0d bytes tag_ready %b expected 0 and 1", out_q.size(), tag_ready_o);
        end
`endif
        out_q.delete();
    endtask

    task automatic test_priority();
        int k;
        int at_eom;
`ifdef FIX_CHECKSUM_EN
        logic [11:0] exp [11] = '{12'hC37, 12'h03D, 12'h362, 12'h001, 12'h831, 12'h430, 12'h03D, 12'h232, 12'h031, 12'h135, 12'h001};
`else
        logic [11:0] exp [4] = '{12'hC37, 12'h03D, 12'h362, 12'h001};
`endif
        tag_valid_i = 1'b1;
        tag_i = 14'd7;
        eom_valid_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tag_ready_o, eom_ready_o} !== 2'b10) begin
            n_fails++;
            $display("FAIL prio_ready: got tag/eom ready %b expected 10", {tag_ready_o, eom_ready_o});
        end
        @(posedge clk); #1;
        tag_valid_i = 1'b0;
        send_val(8'h62, 1'b1);
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (eom_ready_o) break;
        end
        @(posedge clk); #1;
        eom_valid_i = 1'b0;
        at_eom = out_q.size();
        n_checks++;
        if (k == 30 || at_eom != 4) begin
            n_fails++;
            $display("FAIL prio_eom_after_soh: got %0d bytes at eom accept (wait %0d) expected 4", at_eom, k);
        end
        repeat (12) @(posedge clk); #1;
        n_checks++;
        if (out_q.size() != $size(exp)) begin
            n_fails++;
            $display("FAIL prio_count: got %0d bytes expected %0d", out_q.size(), $size(exp));
        end
        for (int i = 0; i < $size(exp) && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL prio_byte%0d: got %h expected %h", i, out_q[i], exp[i]);
            end
        end
        out_q.delete();
    endtask

    initial begin
        test_reset();
        test_tag1_eom();
        test_basic();
        test_stall();
        test_drop();
        test_reset_mid_val();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
